// File: rtl/snake_tile_renderer_if.sv
// Pixel-stream bundle between the VGA timing/background path and the snake overlay.
// The master drives the raster position and background colour; the slave returns the overlaid colour.
interface snake_tile_renderer_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic        screenEnd;
    logic [11:0] bg_color;
    logic [11:0] rgb;
    logic        rgb_active;

    modport master (
        output x, y, active, screenEnd, bg_color,
        input  rgb, rgb_active
    );

    modport slave (
        input  x, y, active, screenEnd, bg_color,
        output rgb, rgb_active
    );
endinterface

// File: rtl/snake_tile_renderer.sv
// Per-pixel snake/food overlay with a per-frame segment snapshot and a 2-cycle pixel pipeline.
// Optional grid lines are enabled by defining SNAKE_GRID_LINES_EN.
module snake_tile_renderer #(
    parameter int unsigned MAX_SEGS   = 100,
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned GRID_W     = 10,
    parameter int unsigned GRID_H     = 10,
    parameter int unsigned TILE_SIZE  = 40,
    parameter int unsigned BOARD_X0   = 48,
    parameter int unsigned BOARD_Y0   = 48,
    parameter logic [11:0] HEAD_COLOR = 12'h0F0,
    parameter logic [11:0] BODY_COLOR = 12'h080,
    parameter logic [11:0] FOOD_COLOR = 12'hF00,
    parameter logic [11:0] DEAD_COLOR = 12'hFFF,
    parameter int unsigned BLINK_LOG2 = 4
) (
    input  logic                          clk25,
    input  logic                          reset,
    snake_tile_renderer_if.slave          vga,
    input  logic [MAX_SEGS*COORD_W-1:0]   seg_x_flat,
    input  logic [MAX_SEGS*COORD_W-1:0]   seg_y_flat,
    input  logic [$clog2(MAX_SEGS+1)-1:0] seg_count,
    input  logic [COORD_W-1:0]            food_x,
    input  logic [COORD_W-1:0]            food_y,
    input  logic                          game_done
);
    localparam int unsigned CNT_W = $clog2(MAX_SEGS + 1);
    localparam int unsigned SUB_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int unsigned FRM_W = BLINK_LOG2 + 1;
    localparam logic [9:0] X_LO = 10'(BOARD_X0);
    localparam logic [9:0] X_HI = 10'(BOARD_X0 + GRID_W * TILE_SIZE);
    localparam logic [9:0] Y_LO = 10'(BOARD_Y0);
    localparam logic [9:0] Y_HI = 10'(BOARD_Y0 + GRID_H * TILE_SIZE);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(TILE_SIZE - 1);
    localparam logic [COORD_W-1:0] GW = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0] GH = COORD_W'(GRID_H);

    logic [MAX_SEGS*COORD_W-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
    logic [COORD_W-1:0] snap_fx_q, snap_fx_d, snap_fy_q, snap_fy_d;
    logic               snap_done_q, snap_done_d;
    logic [FRM_W-1:0]   frame_q, frame_d;

    logic [COORD_W-1:0] col_q, col_d, col_cur, row_q, row_d;
    logic [SUB_W-1:0]   sub_q, sub_d, sub_cur, rsub_q, rsub_d;
    logic [9:0]         prev_y_q, prev_y_d;
    logic               in_col, in_row, on_board;

    logic [MAX_SEGS-1:0] hit_q, hit_d;
    logic                food_hit_q, food_hit_d;
    logic                act_q, act_d;
`ifdef SNAKE_GRID_LINES_EN
    logic                grid_q, grid_d;
`endif
    logic                head, body, dead;
    logic [11:0]         sel;
    logic [11:0]         rgb_q, rgb_d;
    logic                rgb_active_q, rgb_active_d;

    always_comb begin
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_cnt_d  = snap_cnt_q;
        snap_fx_d   = snap_fx_q;
        snap_fy_d   = snap_fy_q;
        snap_done_d = snap_done_q;
        frame_d     = frame_q;
        if (vga.screenEnd) begin
            snap_x_d    = seg_x_flat;
            snap_y_d    = seg_y_flat;
            snap_cnt_d  = (seg_count > CNT_W'(MAX_SEGS)) ? CNT_W'(MAX_SEGS) : seg_count;
            snap_fx_d   = food_x;
            snap_fy_d   = food_y;
            snap_done_d = game_done;
            frame_d     = frame_q + FRM_W'(1);
        end
    end

    // col_q/sub_q hold the tile position of the next pixel, so col_cur/sub_cur line up with x.
    always_comb begin
        in_col  = (vga.x >= X_LO) && (vga.x < X_HI);
        col_cur = col_q;
        sub_cur = sub_q;
        if (vga.x == X_LO) begin
            col_cur = '0;
            sub_cur = '0;
        end
        col_d = col_cur;
        sub_d = sub_cur;
        if (in_col) begin
            if (sub_cur == SUB_LAST) begin
                sub_d = '0;
                col_d = col_cur + COORD_W'(1);
            end else begin
                sub_d = sub_cur + SUB_W'(1);
            end
        end
    end

    // Row state updates on x==0; the _d values are the row used for the whole line.
    always_comb begin
        in_row   = (vga.y >= Y_LO) && (vga.y < Y_HI);
        row_d    = row_q;
        rsub_d   = rsub_q;
        prev_y_d = prev_y_q;
        if (vga.x == 10'd0) begin
            prev_y_d = vga.y;
            if (vga.y == Y_LO) begin
                row_d  = '0;
                rsub_d = '0;
            end else if (vga.y != prev_y_q) begin
                if (rsub_q == SUB_LAST) begin
                    rsub_d = '0;
                    row_d  = row_q + COORD_W'(1);
                end else begin
                    rsub_d = rsub_q + SUB_W'(1);
                end
            end
        end
    end

    always_comb begin
        on_board = in_col && in_row;
        hit_d    = '0;
        for (int unsigned i = 0; i < MAX_SEGS; i++) begin
            hit_d[i] = on_board && (i < 32'(snap_cnt_q))
                && (snap_x_q[i*COORD_W +: COORD_W] == col_cur) && (snap_x_q[i*COORD_W +: COORD_W] < GW)
                && (snap_y_q[i*COORD_W +: COORD_W] == row_d)   && (snap_y_q[i*COORD_W +: COORD_W] < GH);
        end
        food_hit_d = on_board && (snap_fx_q == col_cur) && (snap_fx_q < GW)
                              && (snap_fy_q == row_d) && (snap_fy_q < GH);
        act_d = vga.active;
`ifdef SNAKE_GRID_LINES_EN
        grid_d = on_board && ((sub_cur == '0) || (rsub_d == '0));
`endif
    end

    always_comb begin
        head = hit_q[0];
        body = |hit_q[MAX_SEGS-1:1];
        dead = snap_done_q && frame_q[BLINK_LOG2];
        sel  = vga.bg_color;
        if (food_hit_q) sel = FOOD_COLOR;
`ifdef SNAKE_GRID_LINES_EN
        if (grid_q) sel = 12'h333;
`endif
        if (body) sel = dead ? DEAD_COLOR : BODY_COLOR;
        if (head) sel = dead ? DEAD_COLOR : HEAD_COLOR;
        rgb_d        = act_q ? sel : '0;
        rgb_active_d = act_q;
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_cnt_q   <= '0;
            snap_fx_q    <= GW;
            snap_fy_q    <= GH;
            snap_done_q  <= 1'b0;
            frame_q      <= '0;
            col_q        <= '0;
            sub_q        <= '0;
            row_q        <= '0;
            rsub_q       <= '0;
            prev_y_q     <= '0;
            hit_q        <= '0;
            food_hit_q   <= 1'b0;
            act_q        <= 1'b0;
`ifdef SNAKE_GRID_LINES_EN
            grid_q       <= 1'b0;
`endif
            rgb_q        <= '0;
            rgb_active_q <= 1'b0;
        end else begin
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_cnt_q   <= snap_cnt_d;
            snap_fx_q    <= snap_fx_d;
            snap_fy_q    <= snap_fy_d;
            snap_done_q  <= snap_done_d;
            frame_q      <= frame_d;
            col_q        <= col_d;
            sub_q        <= sub_d;
            row_q        <= row_d;
            rsub_q       <= rsub_d;
            prev_y_q     <= prev_y_d;
            hit_q        <= hit_d;
            food_hit_q   <= food_hit_d;
            act_q        <= act_d;
`ifdef SNAKE_GRID_LINES_EN
            grid_q       <= grid_d;
`endif
            rgb_q        <= rgb_d;
            rgb_active_q <= rgb_active_d;
        end
    end

    assign vga.rgb        = rgb_q;
    assign vga.rgb_active = rgb_active_q;
endmodule

// File: tb/tb_snake_tile_renderer.sv
// Scoreboard bench for snake_tile_renderer: the stimulus pushes expected pixels with their due cycle,
// a negedge monitor pops and compares whenever rgb_active is high.
module tb_snake_tile_renderer;
    localparam int MAX_SEGS = 100;
    localparam int COORD_W  = 8;
    localparam int CNT_W    = 7;
    localparam logic [11:0] BG = 12'h00A;

    logic clk25 = 1'b0;
    logic reset;
    always #5 clk25 = ~clk25;

    snake_tile_renderer_if vga();
    logic [MAX_SEGS*COORD_W-1:0] seg_x_flat, seg_y_flat;
    logic [CNT_W-1:0]            seg_count;
    logic [COORD_W-1:0]          food_x, food_y;
    logic                        game_done;

    snake_tile_renderer #(
        .MAX_SEGS(100), .COORD_W(8), .GRID_W(10), .GRID_H(10), .TILE_SIZE(40),
        .BOARD_X0(48), .BOARD_Y0(48), .HEAD_COLOR(12'h0F0), .BODY_COLOR(12'h080),
        .FOOD_COLOR(12'hF00), .DEAD_COLOR(12'hFFF), .BLINK_LOG2(4)
    ) dut (
        .clk25(clk25), .reset(reset), .vga(vga),
        .seg_x_flat(seg_x_flat), .seg_y_flat(seg_y_flat), .seg_count(seg_count),
        .food_x(food_x), .food_y(food_y), .game_done(game_done)
    );

    typedef struct {
        logic [11:0] color;
        int          due;
        int          px;
        int          py;
    } exp_t;
    exp_t sbq[$];

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference snapshot, updated alongside each screenEnd pulse
    int         m_cnt, m_fx, m_fy;
    int         m_x[MAX_SEGS];
    int         m_y[MAX_SEGS];
    bit         m_done;
    logic [4:0] m_frame;
    bit         chk_line[0:511];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [11:0] exp_color(input int px, input int py);
        int col, row;
        bit inb, head, body, food, dead;
        logic [11:0] c;
        inb  = (px >= 48) && (px < 448) && (py >= 48) && (py < 448);
        col  = (px - 48) / 40;
        row  = (py - 48) / 40;
        head = inb && (m_cnt > 0) && (m_x[0] == col) && (m_y[0] == row);
        body = 1'b0;
        for (int i = 1; i < m_cnt; i++)
            if (inb && (m_x[i] == col) && (m_y[i] == row)) body = 1'b1;
        food = inb && (m_fx == col) && (m_fy == row);
        dead = m_done && m_frame[4];
        c = BG;
        if (food) c = 12'hF00;
`ifdef SNAKE_GRID_LINES_EN
        if (inb && (((px - 48) % 40 == 0) || ((py - 48) % 40 == 0))) c = 12'h333;
`endif
        if (body) c = dead ? 12'hFFF : 12'h080;
        if (head) c = dead ? 12'hFFF : 12'h0F0;
        return c;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_fx = 10; m_fy = 10; m_done = 1'b0; m_frame = '0;
        for (int i = 0; i < MAX_SEGS; i++) begin m_x[i] = 0; m_y[i] = 0; end
    endtask

    task automatic set_seg(input int i, input int sx, input int sy);
        logic [7:0] bx, by;
        bx = 8'(sx); by = 8'(sy);
        seg_x_flat[i*COORD_W +: COORD_W] = bx;
        seg_y_flat[i*COORD_W +: COORD_W] = by;
    endtask

    task automatic drive_pix(input int px, input int py, input bit act);
        @(posedge clk25); #1;
        vga.x = 10'(px); vga.y = 10'(py); vga.active = act; vga.screenEnd = 1'b0;
        if (act) sbq.push_back('{exp_color(px, py), cyc + 2, px, py});
    endtask

    task automatic pulse();
        @(posedge clk25); #1;
        vga.x = 10'd600; vga.y = 10'd500; vga.active = 1'b0; vga.screenEnd = 1'b1;
        m_cnt = (seg_count > 7'd100) ? 100 : int'(seg_count);
        for (int i = 0; i < MAX_SEGS; i++) begin
            m_x[i] = int'(seg_x_flat[i*COORD_W +: COORD_W]);
            m_y[i] = int'(seg_y_flat[i*COORD_W +: COORD_W]);
        end
        m_fx = int'(food_x); m_fy = int'(food_y); m_done = game_done;
        m_frame = m_frame + 5'd1;
        @(posedge clk25); #1;
        vga.screenEnd = 1'b0;
    endtask

    task automatic clear_lines();
        for (int i = 0; i < 512; i++) chk_line[i] = 1'b0;
    endtask

    // Checked lines sweep x=0..499 with active over 40..459; other lines cost one x==0 cycle.
    task automatic scan_frame(input int ymax, input bit mid_change);
        for (int yy = 0; yy <= ymax; yy++) begin
            if (mid_change && yy == 200) set_seg(0, 3, 6);
            if (chk_line[yy]) begin
                for (int xx = 0; xx < 500; xx++) drive_pix(xx, yy, (xx >= 40) && (xx < 460));
            end else begin
                drive_pix(0, yy, 1'b0);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk25);
            if (vga.rgb_active === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rgb_active", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("rgb(%0d,%0d)", e.px, e.py), int'(vga.rgb), int'(e.color));
                    check($sformatf("latency(%0d,%0d)", e.px, e.py), cyc, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1;
        vga.x = '0; vga.y = '0; vga.active = 1'b0; vga.screenEnd = 1'b0; vga.bg_color = BG;
        seg_x_flat = '0; seg_y_flat = '0; seg_count = '0;
        food_x = '0; food_y = '0; game_done = 1'b0;
        model_reset();
        #3;
        check("reset_rgb", int'(vga.rgb), 0);
        check("reset_rgb_active", int'(vga.rgb_active), 0);
        repeat (3) @(posedge clk25);
        #1 reset = 1'b0;

        // Before any screenEnd: empty snapshot, food parked off-board
        clear_lines(); chk_line[60] = 1'b1;
        scan_frame(60, 1'b0);

        // Head alone at (0,0)
        seg_count = 7'd1; set_seg(0, 0, 0); food_x = 8'd12; food_y = 8'd12;
        pulse();
        clear_lines(); chk_line[47] = 1; chk_line[48] = 1; chk_line[87] = 1; chk_line[88] = 1;
        scan_frame(90, 1'b0);

        // Head, two body tiles, food; stale slots beyond count sit on (7,7)
        for (int i = 0; i < MAX_SEGS; i++) set_seg(i, 7, 7);
        seg_count = 7'd3; set_seg(0, 2, 2); set_seg(1, 1, 2); set_seg(2, 0, 2);
        food_x = 8'd5; food_y = 8'd5;
        pulse();
        clear_lines();
        chk_line[127] = 1; chk_line[128] = 1; chk_line[167] = 1; chk_line[168] = 1;
        chk_line[248] = 1; chk_line[287] = 1; chk_line[288] = 1; chk_line[328] = 1;
        scan_frame(330, 1'b0);

        // Mid-frame head move must wait for the next screenEnd
        pulse();
        clear_lines(); chk_line[140] = 1; chk_line[300] = 1;
        scan_frame(300, 1'b1);
        pulse();
        scan_frame(300, 1'b0);

        // Count clamp: 120 requested, all 100 slots tile the board; food hidden under body
        for (int i = 0; i < 99; i++) set_seg(i, i % 10, i / 10);
        set_seg(99, 9, 9);
        seg_count = 7'd120; food_x = 8'd9; food_y = 8'd9;
        pulse();
        clear_lines(); chk_line[48] = 1; chk_line[428] = 1;
        scan_frame(430, 1'b0);

        // Off-board segment at column 10
        seg_count = 7'd2; set_seg(0, 4, 4); set_seg(1, 10, 3); food_x = 8'd9; food_y = 8'd0;
        pulse();
        clear_lines(); chk_line[168] = 1; chk_line[170] = 1; chk_line[210] = 1;
        scan_frame(210, 1'b0);

        // Game-over blink across more than one full period
        seg_count = 7'd2; set_seg(0, 1, 0); set_seg(1, 0, 0);
        food_x = 8'd3; food_y = 8'd0; game_done = 1'b1;
        pulse();
        clear_lines(); chk_line[60] = 1;
        for (int f = 0; f < 34; f++) begin
            scan_frame(60, 1'b0);
            pulse();
        end

        // Asynchronous reset in the middle of line 100
        game_done = 1'b0; seg_count = 7'd3;
        set_seg(0, 2, 2); set_seg(1, 1, 2); set_seg(2, 0, 2);
        food_x = 8'd5; food_y = 8'd5;
        pulse();
        for (int yy = 0; yy < 100; yy++) drive_pix(0, yy, 1'b0);
        for (int xx = 0; xx <= 300; xx++) drive_pix(xx, 100, (xx >= 40));
        #2 reset = 1'b1;
        #1;
        check("async_reset_rgb", int'(vga.rgb), 0);
        check("async_reset_rgb_active", int'(vga.rgb_active), 0);
        sbq.delete();
        model_reset();
        repeat (2) @(posedge clk25);
        #1 reset = 1'b0;
        vga.active = 1'b0;

        clear_lines(); chk_line[140] = 1;
        scan_frame(140, 1'b0);
        seg_count = 7'd0; food_x = 8'd2; food_y = 8'd3;
        pulse();
        clear_lines(); chk_line[140] = 1; chk_line[180] = 1;
        scan_frame(180, 1'b0);

        repeat (5) @(posedge clk25);
        #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
